// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_IF   = 2'd1,
        R_D    = 2'd2
    } resp_t;

    localparam int MAX_WAIT_DEFAULT = 4;
    localparam int WAIT_CNT_W       = 4;

endpackage

// File: rtl/mem_arb_starve_guard.sv
// Counts consecutive cycles a pending fetch has been denied and raises
// o_force_if once it has lost MAX_WAIT times in a row.
module mem_arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_if_req,
    input  logic i_if_gnt,
    output logic o_force_if
);

    localparam logic [WAIT_CNT_W-1:0] LP_MAX = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    // Saturating at LP_MAX keeps the count bounded even if a grant is ever withheld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!i_if_req || i_if_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != LP_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign o_force_if = (r_wait_cnt == LP_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between fetch and data requesters.
// Optional feature macro: MEM_ARB_PERF_EN adds conflict/stall counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic [CNT_W-1:0]  if_stall_cnt
`endif
);

    logic              w_force_if;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic              w_unused;
    resp_t             r_resp;
    logic [DATA_W-1:0] r_if_hold;
    logic [DATA_W-1:0] r_d_hold;

    mem_arb_starve_guard #(
        .MAX_WAIT (MAX_WAIT)
    ) u_guard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_if_req   (if_req),
        .i_if_gnt   (w_if_gnt),
        .o_force_if (w_force_if)
    );

    // Data owns the port unless a contended fetch has reached its wait limit.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (d_req && !(if_req && w_force_if)) begin
            w_d_gnt = 1'b1;
        end else if (if_req) begin
            w_if_gnt = 1'b1;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_en    = w_if_gnt | w_d_gnt;
    assign mem_we    = w_d_gnt & d_we;
    assign mem_wdata = d_wdata;
    assign mem_addr  = w_if_gnt ? if_addr[ADDR_W-1:2] :
                       w_d_gnt  ? d_addr[ADDR_W-1:2]  : '0;
    assign w_unused  = ^{if_addr[1:0], d_addr[1:0]};

    // The response tag tracks who owns the RAM read data on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp    <= R_NONE;
            r_if_hold <= '0;
            r_d_hold  <= '0;
        end else begin
            if (r_resp == R_IF) begin
                r_if_hold <= mem_rdata;
            end
            if (r_resp == R_D) begin
                r_d_hold <= mem_rdata;
            end
            if (w_if_gnt) begin
                r_resp <= R_IF;
            end else if (w_d_gnt && !d_we) begin
                r_resp <= R_D;
            end else begin
                r_resp <= R_NONE;
            end
        end
    end

    assign if_rvalid = (r_resp == R_IF);
    assign d_rvalid  = (r_resp == R_D);
    assign if_rdata  = if_rvalid ? mem_rdata : r_if_hold;
    assign d_rdata   = d_rvalid  ? mem_rdata : r_d_hold;

`ifdef MEM_ARB_PERF_EN
    logic [CNT_W-1:0] r_conflict_cnt;
    logic [CNT_W-1:0] r_if_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
            r_if_stall_cnt <= '0;
        end else begin
            if (if_req && d_req && r_conflict_cnt != '1) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
            if (if_req && !w_if_gnt && r_if_stall_cnt != '1) begin
                r_if_stall_cnt <= r_if_stall_cnt + 1'b1;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign if_stall_cnt = r_if_stall_cnt;
`endif

endmodule
